l2_arbiter: RTL and testbench

//  Shares the single line-wide port of the L2 cache between the L1 I-cache and L1 D-cache miss paths.

---
 rtl/l2_arbiter_if.sv | 56 +++++
 rtl/l2_arbiter.sv | 120 ++++++++++++
 tb/tb_l2_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_arbiter_if.sv
// ---------------------------------------------------------------------------
// l2_arbiter_if
//   Bundles the L1 I-cache miss port, the L1 D-cache miss/writeback port and
//   the single line-wide L2 port that l2_arbiter multiplexes.
//
//   Handshake: a requester raises its read/write strobe with a stable
//   address (and write line) and holds it until it sees a one-cycle *_resp
//   pulse; the returned line is valid on *_rdata from that pulse onwards.
//   The arbiter holds l2_read/l2_write with a stable address/line until the
//   L2 returns a one-cycle l2_resp with l2_rdata valid in that same cycle.
//
//   Modports:
//     slave  - the arbiter's view (takes requests, drives the L2 command)
//     master - the surrounding system's view (L1 caches and L2)
// ---------------------------------------------------------------------------
interface l2_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic [ADDR_W-1:0] i_address;
    logic              i_read;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic [ADDR_W-1:0] d_address;
    logic              d_read;
    logic              d_write;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic [ADDR_W-1:0] l2_address;
    logic              l2_read;
    logic              l2_write;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;

    modport slave (
        input  i_address, i_read,
        output i_rdata, i_resp,
        input  d_address, d_read, d_write, d_wdata,
        output d_rdata, d_resp,
        output l2_address, l2_read, l2_write, l2_wdata,
        input  l2_rdata, l2_resp
    );

    modport master (
        output i_address, i_read,
        input  i_rdata, i_resp,
        output d_address, d_read, d_write, d_wdata,
        input  d_rdata, d_resp,
        input  l2_address, l2_read, l2_write, l2_wdata,
        output l2_rdata, l2_resp
    );
endinterface

// File: rtl/l2_arbiter.sv
// ---------------------------------------------------------------------------
// l2_arbiter
//   Shares the single line-wide L2 port between the L1 I-cache and L1 D-cache
//   miss paths. One requester is granted in IDLE, its command is registered
//   and held on the L2 port until l2_resp, then the line is returned with a
//   one-cycle *_resp pulse, followed by one DONE turnaround cycle.
//
//   Ports:
//     clk       - clock, all state on the rising edge
//     rst       - synchronous reset, active low
//     bus       - l2_arbiter_if.slave (I-cache, D-cache and L2 signals)
//     state_dbg - current FSM state (0 IDLE, 1 BUSY_I, 2 BUSY_D, 3 DONE)
//
//   Configuration macro: L2_ARB_RR_EN
//     defined   - round-robin on contention (grant the side != last_grant)
//     undefined - fixed priority, the D-cache always wins contention
// ---------------------------------------------------------------------------
module l2_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic        clk,
    input  logic        rst,
    l2_arbiter_if.slave bus,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    logic              last_grant_d;   // 1 = D was served last, 0 = I
    logic              op_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic req_i;
    logic req_d;
    logic grant_d;
    logic grant_i;

    assign req_i = bus.i_read;
    assign req_d = bus.d_read | bus.d_write;

`ifdef L2_ARB_RR_EN
    // On contention D only wins when I was the last one served.
    assign grant_d = req_d & (~req_i | ~last_grant_d);
`else
    assign grant_d = req_d;
`endif
    assign grant_i = req_i & ~grant_d;

    // The L2 command is decoded from state plus the registered op, so it
    // stays constant for the whole BUSY phase and drops as soon as the FSM
    // leaves BUSY.
    assign bus.l2_read    = ((state == BUSY_I) || (state == BUSY_D)) && !op_write_q;
    assign bus.l2_write   = (state == BUSY_D) && op_write_q;
    assign bus.l2_address = addr_q;
    assign bus.l2_wdata   = wdata_q;

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            bus.i_rdata  <= '0;
            bus.d_rdata  <= '0;
            bus.i_resp   <= 1'b0;
            bus.d_resp   <= 1'b0;
        end else begin
            bus.i_resp <= 1'b0;
            bus.d_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state      <= BUSY_D;
                        addr_q     <= bus.d_address;
                        // A simultaneous read+write is the writeback half of a
                        // dirty eviction; the refill read is re-requested later.
                        op_write_q <= bus.d_write;
                        wdata_q    <= bus.d_wdata;
                    end else if (grant_i) begin
                        state      <= BUSY_I;
                        addr_q     <= bus.i_address;
                        op_write_q <= 1'b0;
                    end
                end
                BUSY_I: begin
                    if (bus.l2_resp) begin
                        bus.i_rdata  <= bus.l2_rdata;
                        bus.i_resp   <= 1'b1;
                        last_grant_d <= 1'b0;
                        state        <= DONE;
                    end
                end
                BUSY_D: begin
                    if (bus.l2_resp) begin
                        bus.d_rdata  <= bus.l2_rdata;
                        bus.d_resp   <= 1'b1;
                        last_grant_d <= 1'b1;
                        state        <= DONE;
                    end
                end
                // Turnaround cycle so the served requester can drop its held
                // strobe before arbitration looks at it again.
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
module tb_l2_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_I = 2'd1;
    localparam logic [1:0] S_BUSY_D = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;
    int         pass_cnt;
    int         total_cnt;

    l2_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_address = '0;
        bus.i_read    = 1'b0;
        bus.d_address = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_wdata   = '0;
        bus.l2_rdata  = '0;
        bus.l2_resp   = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Called in the first BUSY cycle; pulses l2_resp in BUSY cycle n and
    // returns in the following (DONE) cycle.
    task automatic serve(input int n, input logic [LINE_W-1:0] data);
        for (int k = 1; k < n; k++) tick();
        bus.l2_resp  = 1'b1;
        bus.l2_rdata = data;
        tick();
        bus.l2_resp  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        total_cnt++; if (state_dbg !== S_IDLE) $display("FAIL reset_state: got %0d exp %0d", state_dbg, S_IDLE); else pass_cnt++;
        total_cnt++; if ({bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp} !== 4'b0) $display("FAIL reset_ctrl: got %b exp 0000", {bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp}); else pass_cnt++;
        total_cnt++; if (bus.l2_address !== '0 || bus.l2_wdata !== '0) $display("FAIL reset_l2_bus: addr %h wdata nonzero=%b exp 0", bus.l2_address, |bus.l2_wdata); else pass_cnt++;
        total_cnt++; if (bus.i_rdata !== '0 || bus.d_rdata !== '0) $display("FAIL reset_rdata: i nonzero=%b d nonzero=%b exp 0", |bus.i_rdata, |bus.d_rdata); else pass_cnt++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_i_only();
        logic [LINE_W-1:0] aa;
        aa = {32{8'hAA}};
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_1000;
        tick();
        for (int c = 1; c <= 5; c++) begin
            total_cnt++; if (bus.l2_read !== 1'b1 || bus.l2_write !== 1'b0) $display("FAIL i_only_cmd cyc%0d: rd %b wr %b exp 1 0", c, bus.l2_read, bus.l2_write); else pass_cnt++;
            total_cnt++; if (bus.l2_address !== 32'h0000_1000) $display("FAIL i_only_addr cyc%0d: got %h exp 00001000", c, bus.l2_address); else pass_cnt++;
            total_cnt++; if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) $display("FAIL i_only_early_resp cyc%0d: i %b d %b exp 0 0", c, bus.i_resp, bus.d_resp); else pass_cnt++;
            if (c == 5) begin
                bus.l2_resp  = 1'b1;
                bus.l2_rdata = aa;
            end
            tick();
        end
        bus.l2_resp = 1'b0;
        total_cnt++; if (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b0) $display("FAIL i_only_resp: i %b d %b exp 1 0", bus.i_resp, bus.d_resp); else pass_cnt++;
        total_cnt++; if (bus.i_rdata !== aa) $display("FAIL i_only_rdata: got %h exp %h", bus.i_rdata, aa); else pass_cnt++;
        total_cnt++; if (bus.l2_read !== 1'b0 || state_dbg !== S_DONE) $display("FAIL i_only_done: rd %b state %0d exp 0 %0d", bus.l2_read, state_dbg, S_DONE); else pass_cnt++;
        bus.i_read = 1'b0;
        tick();
        total_cnt++; if (bus.i_resp !== 1'b0 || state_dbg !== S_IDLE) $display("FAIL i_only_idle: resp %b state %0d exp 0 %0d", bus.i_resp, state_dbg, S_IDLE); else pass_cnt++;
    endtask

    task automatic test_d_writeback();
        logic [LINE_W-1:0] w55;
        logic [LINE_W-1:0] r33;
        w55 = {32{8'h55}};
        r33 = {32{8'h33}};
        bus.d_write   = 1'b1;
        bus.d_address = 32'h8000_0040;
        bus.d_wdata   = w55;
        tick();
        for (int c = 1; c <= 4; c++) begin
            total_cnt++; if (bus.l2_write !== 1'b1 || bus.l2_read !== 1'b0) $display("FAIL d_wb_cmd cyc%0d: wr %b rd %b exp 1 0", c, bus.l2_write, bus.l2_read); else pass_cnt++;
            total_cnt++; if (bus.l2_wdata !== w55 || bus.l2_address !== 32'h8000_0040) $display("FAIL d_wb_hold cyc%0d: addr %h exp 80000040", c, bus.l2_address); else pass_cnt++;
            total_cnt++; if (bus.d_resp !== 1'b0) $display("FAIL d_wb_early_resp cyc%0d: got %b exp 0", c, bus.d_resp); else pass_cnt++;
            if (c == 2) begin
                bus.d_address = 32'hDEAD_0000;
                bus.d_wdata   = '0;
            end
            if (c == 4) begin
                bus.l2_resp  = 1'b1;
                bus.l2_rdata = r33;
            end
            tick();
        end
        bus.l2_resp = 1'b0;
        total_cnt++; if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0) $display("FAIL d_wb_resp: d %b i %b exp 1 0", bus.d_resp, bus.i_resp); else pass_cnt++;
        total_cnt++; if (bus.l2_write !== 1'b0 || bus.l2_read !== 1'b0) $display("FAIL d_wb_drop: wr %b rd %b exp 0 0", bus.l2_write, bus.l2_read); else pass_cnt++;
        total_cnt++; if (bus.d_rdata !== r33) $display("FAIL d_wb_rdata_capture: got %h exp %h", bus.d_rdata, r33); else pass_cnt++;
        bus.d_write = 1'b0;
        tick();
        total_cnt++; if (bus.d_resp !== 1'b0 || state_dbg !== S_IDLE) $display("FAIL d_wb_single_pulse: resp %b state %0d exp 0 %0d", bus.d_resp, state_dbg, S_IDLE); else pass_cnt++;
    endtask

    task automatic test_contention();
        logic [1:0]        exp_state [3];
        logic [LINE_W-1:0] data;
`ifdef L2_ARB_RR_EN
        exp_state = '{S_BUSY_D, S_BUSY_I, S_BUSY_D};
`else
        exp_state = '{S_BUSY_D, S_BUSY_D, S_BUSY_D};
`endif
        // Lone I transaction first so the last grant is I.
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_3000;
        tick();
        serve(1, {32{8'h11}});
        bus.i_address = 32'h0000_4000;
        bus.d_read    = 1'b1;
        bus.d_address = 32'h0000_5000;
        tick();
        total_cnt++; if (state_dbg !== S_IDLE) $display("FAIL cont_no_regrant_in_done: state %0d exp %0d", state_dbg, S_IDLE); else pass_cnt++;
        for (int g = 0; g < 3; g++) begin
            tick();
            total_cnt++; if (state_dbg !== exp_state[g]) $display("FAIL cont_grant%0d: state %0d exp %0d", g, state_dbg, exp_state[g]); else pass_cnt++;
            total_cnt++; if (bus.l2_address !== ((exp_state[g] == S_BUSY_D) ? 32'h0000_5000 : 32'h0000_4000)) $display("FAIL cont_addr%0d: got %h", g, bus.l2_address); else pass_cnt++;
            data = {32{8'(8'h20 + g)}};
            serve(2, data);
            if (exp_state[g] == S_BUSY_D) begin
                total_cnt++; if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0 || bus.d_rdata !== data) $display("FAIL cont_d_resp%0d: d %b i %b", g, bus.d_resp, bus.i_resp); else pass_cnt++;
            end else begin
                total_cnt++; if (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b0 || bus.i_rdata !== data) $display("FAIL cont_i_resp%0d: i %b d %b", g, bus.i_resp, bus.d_resp); else pass_cnt++;
            end
            tick();
        end
        bus.d_read = 1'b0;
        tick();
        total_cnt++; if (state_dbg !== S_BUSY_I || bus.l2_read !== 1'b1) $display("FAIL cont_i_finally: state %0d rd %b exp %0d 1", state_dbg, bus.l2_read, S_BUSY_I); else pass_cnt++;
        serve(1, {32{8'h77}});
        total_cnt++; if (bus.i_resp !== 1'b1 || bus.i_rdata !== {32{8'h77}}) $display("FAIL cont_i_final_resp: resp %b rdata %h", bus.i_resp, bus.i_rdata); else pass_cnt++;
        bus.i_read = 1'b0;
        tick();
    endtask

    task automatic test_rw_both();
        bus.d_read    = 1'b1;
        bus.d_write   = 1'b1;
        bus.d_address = 32'h0000_2000;
        bus.d_wdata   = {32{8'hC3}};
        tick();
        total_cnt++; if (bus.l2_write !== 1'b1 || bus.l2_read !== 1'b0) $display("FAIL rw_write_first: wr %b rd %b exp 1 0", bus.l2_write, bus.l2_read); else pass_cnt++;
        total_cnt++; if (bus.l2_wdata !== {32{8'hC3}} || bus.l2_address !== 32'h0000_2000) $display("FAIL rw_write_bus: addr %h", bus.l2_address); else pass_cnt++;
        serve(2, {32{8'h00}});
        total_cnt++; if (bus.d_resp !== 1'b1) $display("FAIL rw_write_resp: got %b exp 1", bus.d_resp); else pass_cnt++;
        bus.d_write = 1'b0;
        tick();
        tick();
        total_cnt++; if (bus.l2_read !== 1'b1 || bus.l2_write !== 1'b0 || bus.l2_address !== 32'h0000_2000) $display("FAIL rw_read_after: rd %b wr %b addr %h", bus.l2_read, bus.l2_write, bus.l2_address); else pass_cnt++;
        serve(3, {32{8'h5A}});
        total_cnt++; if (bus.d_resp !== 1'b1 || bus.d_rdata !== {32{8'h5A}}) $display("FAIL rw_read_resp: resp %b rdata %h", bus.d_resp, bus.d_rdata); else pass_cnt++;
        bus.d_read = 1'b0;
        tick();
    endtask

    task automatic test_spurious_resp();
        bus.l2_resp  = 1'b1;
        bus.l2_rdata = {32{8'hFF}};
        tick();
        bus.l2_resp = 1'b0;
        total_cnt++; if (state_dbg !== S_IDLE) $display("FAIL spur_state: got %0d exp %0d", state_dbg, S_IDLE); else pass_cnt++;
        total_cnt++; if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) $display("FAIL spur_resp: i %b d %b exp 0 0", bus.i_resp, bus.d_resp); else pass_cnt++;
        total_cnt++; if (bus.i_rdata !== {32{8'h77}} || bus.d_rdata !== {32{8'h5A}}) $display("FAIL spur_rdata: i %h d %h", bus.i_rdata, bus.d_rdata); else pass_cnt++;
        tick();
        total_cnt++; if (state_dbg !== S_IDLE || bus.l2_read !== 1'b0) $display("FAIL spur_after: state %0d rd %b", state_dbg, bus.l2_read); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bus.d_write   = 1'b1;
        bus.d_address = 32'h0000_6000;
        bus.d_wdata   = {32{8'h0F}};
        tick();
        total_cnt++; if (state_dbg !== S_BUSY_D || bus.l2_write !== 1'b1) $display("FAIL rmid_busy: state %0d wr %b", state_dbg, bus.l2_write); else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++; if (state_dbg !== S_IDLE) $display("FAIL rmid_state: got %0d exp %0d", state_dbg, S_IDLE); else pass_cnt++;
        total_cnt++; if ({bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp} !== 4'b0) $display("FAIL rmid_ctrl: got %b exp 0000", {bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp}); else pass_cnt++;
        total_cnt++; if (bus.l2_address !== '0 || bus.l2_wdata !== '0 || bus.i_rdata !== '0 || bus.d_rdata !== '0) $display("FAIL rmid_data: addr %h", bus.l2_address); else pass_cnt++;
        rst         = 1'b1;
        bus.d_write = 1'b0;
        tick();
        total_cnt++; if (bus.d_resp !== 1'b0 || state_dbg !== S_IDLE) $display("FAIL rmid_no_resp: resp %b state %0d", bus.d_resp, state_dbg); else pass_cnt++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b0;
        clear_inputs();
        test_reset();
        test_i_only();
        test_d_writeback();
        test_contention();
        test_rw_both();
        test_spurious_resp();
        test_reset_mid();
        apply_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
